// File: rtl/fp_mult_arb_pkg.sv
// Shared types and width helpers for the round-robin fixed-point multiplier arbiter.
`default_nettype none
/*==========================================================================
 * Module      : fp_mult_arb_pkg
 * Description : FSM state encoding and width helpers for fp_mult_arbiter
 * Revision    : 1.0  initial release
 *==========================================================================*/
package fp_mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int int_len(input int wi1, input int wi2);
    return wi1 + wi2;
  endfunction

  function automatic int frc_len(input int wf1, input int wf2);
    return wf1 + wf2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mult_fmt.sv
// Combinational reformatter: full-precision signed product to WIO.WFO.
`default_nettype none
/*==========================================================================
 * Module      : fp_mult_fmt
 * Description : pads/truncates fraction, sign-extends or wraps integer part;
 *               saturates on integer overflow when FP_MULT_ARB_SAT_EN is set
 * Revision    : 1.0  initial release
 *==========================================================================*/
module fp_mult_fmt #(
  parameter int INTL = 6,
  parameter int FRCL = 8,
  parameter int WIO  = 1,
  parameter int WFO  = 15
) (
  input  logic [INTL+FRCL-1:0] prod_i,
  output logic [WIO+WFO-1:0]   res_o
);

  localparam int PW = INTL + FRCL;
  localparam int WO = WIO + WFO;

  logic [INTL-1:0] w_ip;
  logic [WFO-1:0]  w_frac;
  logic [WIO-1:0]  w_int;
  logic            w_ovf;

  assign w_ip = prod_i[PW-1:FRCL];

  if (WFO > FRCL) begin : g_frac_pad
    assign w_frac = {prod_i[FRCL-1:0], {(WFO-FRCL){1'b0}}};
  end else if (WFO == FRCL) begin : g_frac_exact
    assign w_frac = prod_i[FRCL-1:0];
  end else begin : g_frac_trunc
    // Dropping LSBs of a two's-complement value rounds toward -inf.
    logic w_unused_lsb;
    assign w_frac       = prod_i[FRCL-1 -: WFO];
    assign w_unused_lsb = ^prod_i[FRCL-WFO-1:0];
  end

  if (WIO > INTL) begin : g_int_ext
    assign w_int = {{(WIO-INTL){w_ip[INTL-1]}}, w_ip};
    assign w_ovf = 1'b0;
  end else if (WIO == INTL) begin : g_int_exact
    assign w_int = w_ip;
    assign w_ovf = 1'b0;
  end else begin : g_int_wrap
    assign w_ovf = (w_ip[INTL-1:WIO-1] != {(INTL-WIO+1){w_ip[INTL-1]}});
    if (WIO == 1) begin : g_sign_only
      assign w_int = w_ip[INTL-1];
    end else begin : g_sign_low
      assign w_int = {w_ip[INTL-1], w_ip[WIO-2:0]};
    end
  end

`ifdef FP_MULT_ARB_SAT_EN
  assign res_o = !w_ovf       ? {w_int, w_frac} :
                 w_ip[INTL-1] ? {1'b1, {(WO-1){1'b0}}} :
                                {1'b0, {(WO-1){1'b1}}};
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign res_o        = {w_int, w_frac};
`endif

endmodule
`default_nettype wire

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one signed fixed-point multiplier among NREQ requesters.
`default_nettype none
/*==========================================================================
 * Module      : fp_mult_arbiter
 * Description : round-robin grant, operand/result registers, IDLE-MUL-OUT
 *               FSM; define FP_MULT_ARB_SAT_EN for saturating integer part
 * Revision    : 1.0  initial release
 *==========================================================================*/
module fp_mult_arbiter
  import fp_mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WI1  = 4,
  parameter int WF1  = 3,
  parameter int WI2  = 2,
  parameter int WF2  = 5,
  parameter int WIO  = 1,
  parameter int WFO  = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*(WI1+WF1)-1:0] in1_bus_i,
  input  logic [NREQ*(WI2+WF2)-1:0] in2_bus_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [id_w(NREQ)-1:0]     res_id_o,
  output logic [WIO+WFO-1:0]        res_out_o,
  output logic                      busy_o
);

  localparam int W1   = WI1 + WF1;
  localparam int W2   = WI2 + WF2;
  localparam int ID_W = id_w(NREQ);
  localparam int INTL = int_len(WI1, WI2);
  localparam int FRCL = frc_len(WF1, WF2);
  localparam int PW   = INTL + FRCL;
  localparam int WO   = WIO + WFO;

  state_e state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] id_q;
  logic signed [W1-1:0] op1_q;
  logic signed [W2-1:0] op2_q;
  logic [WO-1:0] res_q;

  logic [ID_W-1:0]      w_win;
  logic                 w_found;
  logic signed [W1-1:0] w_in1 [NREQ];
  logic signed [W2-1:0] w_in2 [NREQ];
  logic signed [PW-1:0] w_prod;
  logic [WO-1:0]        w_fmt;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_in1[i] = in1_bus_i[i*W1 +: W1];
    assign w_in2[i] = in2_bus_i[i*W2 +: W2];
  end

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!w_found && req_valid_i[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    req_ready_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_found && rst_ni) begin
          req_ready_o[w_win] = 1'b1;
          rr_d    = (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
          state_d = ST_MUL;
        end
      end
      ST_MUL:  state_d = ST_OUT;
      ST_OUT:  if (res_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_prod = PW'(op1_q) * PW'(op2_q);

  fp_mult_fmt #(
    .INTL (INTL),
    .FRCL (FRCL),
    .WIO  (WIO),
    .WFO  (WFO)
  ) u_fmt (
    .prod_i (w_prod),
    .res_o  (w_fmt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (state_q == ST_IDLE && w_found) begin
        id_q  <= w_win;
        op1_q <= w_in1[w_win];
        op2_q <= w_in2[w_win];
      end
      if (state_q == ST_MUL) begin
        res_q <= w_fmt;
      end
    end
  end

  assign res_valid_o = (state_q == ST_OUT);
  assign busy_o      = (state_q != ST_IDLE);
  assign res_id_o    = id_q;
  assign res_out_o   = res_q;

endmodule
`default_nettype wire
